// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and the single-port RAM.
// slave modport is the arbiter side; master modport is the requester/RAM side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  // Requester port 0 (CPU load/store path)
  logic              m0_req;
  logic              m0_we;
  logic [31:0]       m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_ack;
  logic              m0_rvalid;
  logic [31:0]       m0_rdata;
  // Requester port 1 (secondary master)
  logic              m1_req;
  logic              m1_we;
  logic [31:0]       m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_ack;
  logic              m1_rvalid;
  logic [31:0]       m1_rdata;
  // Address error, pulses with ack
  logic              err;
  // Data RAM side
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic [31:0]       mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output err,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  err,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM. Translates virtual addresses
// (ADDR_BASE-relative) to RAM word addresses and sequences IDLE -> ACCESS -> WAIT -> RESP.
// Optional macro DMEM_ARB_RR_EN: round-robin between simultaneous requesters;
// when undefined, port 0 has fixed priority.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned RD_LAT    = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  dmem_arbiter_if.slave io_bus
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACCESS = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [1:0]  S_RESP   = 2'd3;
  localparam logic [2:0]  LAT      = 3'(RD_LAT);
  // Byte span of the RAM window; 33 bits so a 30-bit word address still fits
  localparam logic [32:0] SPAN     = 33'd1 << (ADDR_W + 2);

  logic [1:0]        r_state;
  logic              r_owner;   // 1: port 1 owns the current transaction
  logic              r_we;
  logic              r_err;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_m0_rdata;
  logic [31:0]       r_m1_rdata;

  logic              w_any_req;
  logic              w_grant1;
  logic              w_sel_we;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [31:0]       w_offset;
  logic              w_oor;
  logic [31:0]       w_cap_data;

  assign w_any_req = io_bus.m0_req | io_bus.m1_req;

`ifdef DMEM_ARB_RR_EN
  logic r_rr_ptr;

  // Pointer flips on every accepted transaction; a lone requester ignores it
  assign w_grant1 = io_bus.m1_req & (~io_bus.m0_req | r_rr_ptr);

  // Round-robin pointer update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end
`else
  // Fixed priority: port 0 wins simultaneous requests
  assign w_grant1 = io_bus.m1_req & ~io_bus.m0_req;
`endif

  assign w_sel_we    = w_grant1 ? io_bus.m1_we    : io_bus.m0_we;
  assign w_sel_addr  = w_grant1 ? io_bus.m1_addr  : io_bus.m0_addr;
  assign w_sel_wdata = w_grant1 ? io_bus.m1_wdata : io_bus.m0_wdata;

  // Modulo subtraction; addresses below the base are rejected explicitly so they
  // cannot wrap into the window
  assign w_offset = w_sel_addr - ADDR_BASE;
  assign w_oor    = (w_sel_addr < ADDR_BASE) | ({1'b0, w_offset} >= SPAN);

  // Out-of-range reads return zero instead of whatever the RAM produces
  assign w_cap_data = r_err ? 32'd0 : io_bus.mem_rdata;

  // Access sequencer: latch winner in IDLE, drive RAM in ACCESS, count read latency in WAIT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= 3'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_m0_rdata  <= 32'd0;
      r_m1_rdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_grant1;
            r_we        <= w_sel_we;
            r_err       <= w_oor;
            r_mem_addr  <= w_offset[ADDR_W+1:2];
            r_mem_wdata <= w_sel_wdata;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // Counter reaches zero on this edge: RAM data is valid now
          if (r_cnt <= 3'd1) begin
            if (r_owner) begin
              r_m1_rdata <= w_cap_data;
            end else begin
              r_m0_rdata <= w_cap_data;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.m0_ack    = (r_state == S_ACCESS) & ~r_owner;
  assign io_bus.m1_ack    = (r_state == S_ACCESS) &  r_owner;
  assign io_bus.m0_rvalid = (r_state == S_RESP)   & ~r_owner;
  assign io_bus.m1_rvalid = (r_state == S_RESP)   &  r_owner;
  assign io_bus.m0_rdata  = r_m0_rdata;
  assign io_bus.m1_rdata  = r_m1_rdata;
  assign io_bus.err       = (r_state == S_ACCESS) & r_err;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  // Gated by reset so an aborted write never reaches the RAM
  assign io_bus.mem_wren  = (r_state == S_ACCESS) & r_we & ~r_err & ~i_rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .ADDR_BASE (32'h1000_0000),
    .ADDR_W    (ADDR_W),
    .RD_LAT    (1)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, read latency 1
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic exp_w;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'd0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'd0; bus.m0_wdata = 32'd0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'd0; bus.m1_wdata = 32'd0;

    // Reset state
    repeat (2) step();
    check("rst_m0_ack",    bus.m0_ack,    32'd0);
    check("rst_m1_ack",    bus.m1_ack,    32'd0);
    check("rst_m0_rvalid", bus.m0_rvalid, 32'd0);
    check("rst_m1_rvalid", bus.m1_rvalid, 32'd0);
    check("rst_err",       bus.err,       32'd0);
    check("rst_wren",      bus.mem_wren,  32'd0);
    check("rst_m0_rdata",  bus.m0_rdata,  32'd0);
    check("rst_m1_rdata",  bus.m1_rdata,  32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    // Port 0 write 0x10000010 <- DEADBEEF
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h1000_0010; bus.m0_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_m0_ack",    bus.m0_ack,    32'd1);
    check("wr_m1_ack",    bus.m1_ack,    32'd0);
    check("wr_wren",      bus.mem_wren,  32'd1);
    check("wr_mem_addr",  32'(bus.mem_addr), 32'd4);
    check("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("wr_err",       bus.err,       32'd0);
    bus.m0_req = 1'b0;
    step();
    check("wr_ack_drop",  bus.m0_ack,    32'd0);
    check("wr_wren_drop", bus.mem_wren,  32'd0);

    // Port 1 read back 0x10000010
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h1000_0010;
    step();
    check("rd_m1_ack",    bus.m1_ack,    32'd1);
    check("rd_m0_ack",    bus.m0_ack,    32'd0);
    check("rd_wren",      bus.mem_wren,  32'd0);
    check("rd_mem_addr",  32'(bus.mem_addr), 32'd4);
    bus.m1_req = 1'b0;
    step();
    check("rd_wait_rv",   bus.m1_rvalid, 32'd0);
    check("rd_wait_ack",  bus.m1_ack,    32'd0);
    step();
    check("rd_m1_rvalid", bus.m1_rvalid, 32'd1);
    check("rd_m1_rdata",  bus.m1_rdata,  32'hDEAD_BEEF);
    check("rd_m0_rvalid", bus.m0_rvalid, 32'd0);
    check("rd_m0_rdata",  bus.m0_rdata,  32'd0);
    step();
    check("rd_rv_drop",   bus.m1_rvalid, 32'd0);
    check("rd_rdata_hold", bus.m1_rdata, 32'hDEAD_BEEF);

    // Both ports read continuously for four transactions
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1000_0010;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h1000_0010;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_w = i[0];
`else
      exp_w = 1'b0;
`endif
      step();
      check($sformatf("arb%0d_m0_ack", i), bus.m0_ack, 32'(!exp_w));
      check($sformatf("arb%0d_m1_ack", i), bus.m1_ack, 32'(exp_w));
      if (exp_w) bus.m1_req = 1'b0;
      else       bus.m0_req = 1'b0;
      step();
      step();
      check($sformatf("arb%0d_m0_rv", i), bus.m0_rvalid, 32'(!exp_w));
      check($sformatf("arb%0d_m1_rv", i), bus.m1_rvalid, 32'(exp_w));
      bus.m0_req = 1'b1;
      bus.m1_req = 1'b1;
      step();
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check("arb_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    step();

    // Out-of-range write below the base
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0FFF_FFFC; bus.m0_wdata = 32'h1234_5678;
    step();
    check("oorw_ack",  bus.m0_ack,   32'd1);
    check("oorw_err",  bus.err,      32'd1);
    check("oorw_wren", bus.mem_wren, 32'd0);
    bus.m0_req = 1'b0;
    step();
    check("oorw_err_drop", bus.err,      32'd0);
    check("oorw_wren2",    bus.mem_wren, 32'd0);

    // Out-of-range read just past the top of the window
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1001_0000;
    step();
    check("oorr_ack",  bus.m0_ack,   32'd1);
    check("oorr_err",  bus.err,      32'd1);
    check("oorr_wren", bus.mem_wren, 32'd0);
    bus.m0_req = 1'b0;
    step();
    check("oorr_wait_err", bus.err,       32'd0);
    check("oorr_wait_rv",  bus.m0_rvalid, 32'd0);
    step();
    check("oorr_rvalid",   bus.m0_rvalid, 32'd1);
    check("oorr_rdata",    bus.m0_rdata,  32'd0);
    check("oorr_m1_rdata", bus.m1_rdata,  32'hDEAD_BEEF);
    step();

    // Reset during WAIT aborts the read
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1000_0010;
    step();
    check("abrt_ack", bus.m0_ack, 32'd1);
    bus.m0_req = 1'b0;
    step();
    check("abrt_wait_rv", bus.m0_rvalid, 32'd0);
    rst = 1'b1;
    step();
    check("abrt_rv0",    bus.m0_rvalid, 32'd0);
    check("abrt_rdata",  bus.m0_rdata,  32'd0);
    check("abrt_maddr",  32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    step();
    check("abrt_rv1", bus.m0_rvalid, 32'd0);
    step();
    check("abrt_rv2", bus.m0_rvalid, 32'd0);

    // Normal write after the abort
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h1000_0020; bus.m0_wdata = 32'hCAFE_F00D;
    step();
    check("post_ack",    bus.m0_ack,    32'd1);
    check("post_wren",   bus.mem_wren,  32'd1);
    check("post_maddr",  32'(bus.mem_addr), 32'd8);
    check("post_wdata",  bus.mem_wdata, 32'hCAFE_F00D);
    check("post_err",    bus.err,       32'd0);
    bus.m0_req = 1'b0;
    step();
    check("post_ack_drop", bus.m0_ack, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
